kf_bus_decoder: RTL and testbench
=================================

# kf_bus_decoder

Parametrised bus decoder and read-data steering unit for the KFPC-XT chipset. It replaces fixed I/O block decoding with CHANNELS runtime-programmable windows, each with its own base, mask, I/O or memory space select, and wait-state count. It sits between the CPU bus-command signals and the peripheral cores. It drives registered per-channel chip selects, an I/O-channel-ready handshake and the chipset read-data mux.

## Interface
- CHANNELS, 8, number of decode windows/channels (1-16)
- ADDR_WIDTH, 20, bus address width
- DATA_WIDTH, 8, bus data width
- WAIT_WIDTH, 3, width of per-channel wait-state count
- clock  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- io_read_command_n, io_write_command_n, memory_read_command_n, memory_write_command_n  in  1 each  bus commands, active low
- address_enable_n  in  1  low = CPU-owned cycle; decode only while low
- address  in  ADDR_WIDTH  bus address
- channel_data_bus_out  in  CHANNELS*DATA_WIDTH  read data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- cfg_write  in  1  one-cycle strobe; loads the window selected by cfg_channel
- cfg_channel  in  4  window index
- cfg_enable, cfg_memory  in  1 each  window enable; 1 = memory space, 0 = I/O space
- cfg_base, cfg_mask  in  ADDR_WIDTH each  match when ((address ^ base) & mask) == 0
- cfg_wait  in  WAIT_WIDTH  wait states inserted for the window
- chip_select_n  out  CHANNELS  registered, one-hot-low
- io_channel_ready  out  1  low while wait states are pending
- data_bus_out  out  DATA_WIDTH  steered read data
- data_bus_out_from_chipset  out  1  chipset drives data_bus_out
- miss_count  out  8  saturating count of unclaimed commands

## Operation
- Reset values:
  - Windows: all disabled, base 0, mask all-ones, wait 0.
  - Outputs: chip_select_n all-ones, io_channel_ready 1, data_bus_out 0, data_bus_out_from_chipset 0, miss_count 0.
  - FSM: IDLE.
- Command valid: address_enable_n low and exactly one command_n low. The space (I/O or memory) comes from the active command.
- Hit: window enabled, cfg_memory matches the space, and the address matches. If several windows hit, the lowest index wins.
- FSM states: IDLE, WAIT, READY, MISS, RECOVER.
  - IDLE, valid command and hit: latch channel index, read flag and wait count. Go to WAIT if wait count > 0, otherwise READY.
  - IDLE, valid command and no hit: go to MISS and increment miss_count (saturates at 255).
  - IDLE, two or more command_n low: treated as a miss.
  - WAIT: decrement the counter each clock; go to READY when it reaches 1.
  - WAIT, READY, MISS, any command no longer valid (all command_n high or address_enable_n high): go to RECOVER.
  - RECOVER: lasts exactly 1 cycle, chip_select_n all-ones, then IDLE.
- Outputs by state:
  - chip_select_n[latched] is low in WAIT and READY, all-ones otherwise.
  - io_channel_ready is low only in WAIT.
  - Read in READY: data_bus_out is registered each clock from the latched channel, and data_bus_out_from_chipset is 1.
  - Writes, MISS and other states: data_bus_out_from_chipset is 0 and data_bus_out holds its last value.
- Configuration:
  - cfg_write with cfg_channel >= CHANNELS is ignored.
  - Writes take effect on the next decode. An in-flight access uses its latched index and count.
- Address changes after the decode are ignored for that command.

## Timing
- A command first seen low at edge k is decoded at edge k, so chip_select_n falls after edge k.
- With wait count W > 0, io_channel_ready is low from edge k to edge k+W and high after edge k+W.
- Read data is first valid after the first READY edge:
  - W = 0: edge k+1.
  - W > 0: edge k+W+1.
- Command deasserted at edge m: chip_select_n rises after edge m, and a new decode is possible at edge m+2.
- Back-to-back commands with no idle gap still pass through RECOVER.
- reset_n low mid-access: all outputs return to reset values immediately (asynchronous), and the FSM goes to IDLE.

## Structure
- Package kf_bus_decoder_pkg:
  - decoder_state_t enum.
  - bus_space_t enum (IO, MEMORY).
  - Channel-index width constant (4).
- Sub-module kf_bus_window, instantiated CHANNELS times:
  - Holds one window's enable, space, base, mask and wait registers.
  - Outputs a combinational hit and its wait count.
- Top level contains the priority encoder, FSM, wait counter, data mux/register and miss counter.

## Test plan
- Program ch1 I/O base 0x00020 mask 0xFFFE0 wait 0, then I/O read at 0x00021 with channel 1 data 0x5A:
  - chip_select_n = 0xFD after the decode edge.
  - data_bus_out = 0x5A with data_bus_out_from_chipset = 1 one cycle later.
  - io_channel_ready stays high.
- Program ch4 memory base 0xB8000 mask 0xFC000 wait 3, then memory write at 0xB8010:
  - io_channel_ready low for exactly 3 cycles.
  - chip_select_n[4] low until the command rises, then all-ones.
- Enable ch2 and ch5 with the same I/O window, then I/O read:
  - Only chip_select_n[2] goes low.
- Commands with no hit, and with io_read_command_n and io_write_command_n low together:
  - No chip select asserted.
  - miss_count increments per command and saturates at 255 after 300 misses.
- Assert reset_n low during WAIT with wait 7:
  - chip_select_n all-ones and io_channel_ready 1 without waiting for a clock edge.
  - Next command decodes normally.
- cfg_write to ch1 with a new base during an active ch1 access:
  - Current access is unaffected.
  - Next command decodes against the new base.
- cfg_channel = 12 with CHANNELS = 8:
  - Write is ignored.

Source files
------------

// File: rtl/kf_bus_decoder_pkg.sv
// Shared types and constants for the KFPC-XT programmable bus decoder.
package kf_bus_decoder_pkg;

    // Width of a window/channel index (up to 16 windows).
    localparam int CH_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_READY   = 3'd2,
        ST_MISS    = 3'd3,
        ST_RECOVER = 3'd4
    } decoder_state_t;

    typedef enum logic {
        IO     = 1'b0,
        MEMORY = 1'b1
    } bus_space_t;

    // True when exactly one of the four active-low bus commands is asserted.
    function automatic logic single_low(input logic [3:0] cmd_n);
        logic [3:0] low;
        low = ~cmd_n;
        return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/kf_bus_window.sv
// One runtime-programmable decode window: holds its configuration and
// reports a combinational hit for the current address/space.
module kf_bus_window
    import kf_bus_decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int WAIT_WIDTH = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_cfg_load,
    input  logic                  i_cfg_enable,
    input  logic                  i_cfg_memory,
    input  logic [ADDR_WIDTH-1:0] i_cfg_base,
    input  logic [ADDR_WIDTH-1:0] i_cfg_mask,
    input  logic [WAIT_WIDTH-1:0] i_cfg_wait,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  bus_space_t            i_space,
    output logic                  o_hit,
    output logic [WAIT_WIDTH-1:0] o_wait
);

    logic                  r_enable;
    bus_space_t            r_space;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_mask;
    logic [WAIT_WIDTH-1:0] r_wait;

    // Window configuration registers; reset leaves the window disabled.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_enable <= 1'b0;
            r_space  <= IO;
            r_base   <= '0;
            r_mask   <= '1;
            r_wait   <= '0;
        end else if (i_cfg_load) begin
            r_enable <= i_cfg_enable;
            r_space  <= bus_space_t'(i_cfg_memory);
            r_base   <= i_cfg_base;
            r_mask   <= i_cfg_mask;
            r_wait   <= i_cfg_wait;
        end
    end

    assign o_hit  = r_enable && (r_space == i_space) &&
                    (((i_address ^ r_base) & r_mask) == '0);
    assign o_wait = r_wait;

endmodule

// File: rtl/kf_bus_decoder.sv
// Programmable bus decoder: priority-encodes window hits, runs the access
// FSM with wait-state insertion, and steers channel read data to the bus.
module kf_bus_decoder
    import kf_bus_decoder_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_WIDTH = 3
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           io_read_command_n,
    input  logic                           io_write_command_n,
    input  logic                           memory_read_command_n,
    input  logic                           memory_write_command_n,
    input  logic                           address_enable_n,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic [CHANNELS*DATA_WIDTH-1:0] channel_data_bus_out,
    input  logic                           cfg_write,
    input  logic [3:0]                     cfg_channel,
    input  logic                           cfg_enable,
    input  logic                           cfg_memory,
    input  logic [ADDR_WIDTH-1:0]          cfg_base,
    input  logic [ADDR_WIDTH-1:0]          cfg_mask,
    input  logic [WAIT_WIDTH-1:0]          cfg_wait,
    output logic [CHANNELS-1:0]            chip_select_n,
    output logic                           io_channel_ready,
    output logic [DATA_WIDTH-1:0]          data_bus_out,
    output logic                           data_bus_out_from_chipset,
    output logic [7:0]                     miss_count
);

    logic [3:0]            w_cmd_n;
    logic                  w_active;
    logic                  w_valid;
    bus_space_t            w_space;
    logic                  w_is_read;
    logic [CHANNELS-1:0]   w_hit;
    logic [WAIT_WIDTH-1:0] w_wait [CHANNELS];
    logic                  w_any_hit;
    logic [CH_IDX_W-1:0]   w_hit_idx;
    logic [WAIT_WIDTH-1:0] w_hit_wait;

    decoder_state_t        r_state, w_state_next;
    logic [CH_IDX_W-1:0]   r_chan, w_chan_next;
    logic [WAIT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                  r_read, w_read_next;
    logic                  w_miss_inc;
    logic [CHANNELS-1:0]   w_cs_n_next;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_capture;

    logic [CHANNELS-1:0]   r_cs_n;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_from_chipset;
    logic [7:0]            r_miss;

    assign w_cmd_n   = {memory_write_command_n, memory_read_command_n,
                        io_write_command_n, io_read_command_n};
    assign w_active  = !address_enable_n && (w_cmd_n != 4'hF);
    assign w_valid   = !address_enable_n && single_low(w_cmd_n);
    assign w_space   = (!memory_read_command_n || !memory_write_command_n) ? MEMORY : IO;
    assign w_is_read = !io_read_command_n || !memory_read_command_n;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_win
        kf_bus_window #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .WAIT_WIDTH (WAIT_WIDTH)
        ) u_win (
            .i_clock      (clock),
            .i_reset_n    (reset_n),
            .i_cfg_load   (cfg_write && (cfg_channel == CH_IDX_W'(g))),
            .i_cfg_enable (cfg_enable),
            .i_cfg_memory (cfg_memory),
            .i_cfg_base   (cfg_base),
            .i_cfg_mask   (cfg_mask),
            .i_cfg_wait   (cfg_wait),
            .i_address    (address),
            .i_space      (w_space),
            .o_hit        (w_hit[g]),
            .o_wait       (w_wait[g])
        );
    end

    // Priority encoder: the lowest-indexed hitting window claims the cycle.
    always_comb begin
        w_any_hit  = 1'b0;
        w_hit_idx  = '0;
        w_hit_wait = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit  = 1'b1;
                w_hit_idx  = CH_IDX_W'(i);
                w_hit_wait = w_wait[i];
            end
        end
    end

    // Next-state logic; the index, direction and wait count are latched on decode only.
    always_comb begin
        w_state_next = r_state;
        w_chan_next  = r_chan;
        w_cnt_next   = r_cnt;
        w_read_next  = r_read;
        w_miss_inc   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_active) begin
                    if (w_valid && w_any_hit) begin
                        w_chan_next  = w_hit_idx;
                        w_read_next  = w_is_read;
                        w_cnt_next   = w_hit_wait;
                        w_state_next = (w_hit_wait != '0) ? ST_WAIT : ST_READY;
                    end else begin
                        w_state_next = ST_MISS;
                        w_miss_inc   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_active) begin
                    w_state_next = ST_RECOVER;
                end else if (r_cnt == WAIT_WIDTH'(1)) begin
                    w_state_next = ST_READY;
                end else begin
                    w_cnt_next = r_cnt - WAIT_WIDTH'(1);
                end
            end
            ST_READY, ST_MISS: begin
                if (!w_active) w_state_next = ST_RECOVER;
            end
            ST_RECOVER: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Chip-select pattern for the state being entered, plus the latched channel's read data.
    always_comb begin
        w_cs_n_next = '1;
        w_rd_data   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((w_state_next == ST_WAIT || w_state_next == ST_READY) &&
                (CH_IDX_W'(i) == w_chan_next)) begin
                w_cs_n_next[i] = 1'b0;
            end
            if (CH_IDX_W'(i) == r_chan) begin
                w_rd_data = channel_data_bus_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Data is only driven once the access has already spent a cycle in READY and stays there.
    assign w_capture = (r_state == ST_READY) && (w_state_next == ST_READY) && r_read;

    // FSM state and latched access context.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_chan  <= '0;
            r_cnt   <= '0;
            r_read  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_chan  <= w_chan_next;
            r_cnt   <= w_cnt_next;
            r_read  <= w_read_next;
        end
    end

    // Registered bus-facing outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n         <= '1;
            r_ready        <= 1'b1;
            r_data         <= '0;
            r_from_chipset <= 1'b0;
        end else begin
            r_cs_n         <= w_cs_n_next;
            r_ready        <= (w_state_next != ST_WAIT);
            r_from_chipset <= w_capture;
            if (w_capture) r_data <= w_rd_data;
        end
    end

    // Saturating count of commands that no window claimed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_miss <= '0;
        end else if (w_miss_inc && (r_miss != 8'hFF)) begin
            r_miss <= r_miss + 8'd1;
        end
    end

    assign chip_select_n             = r_cs_n;
    assign io_channel_ready          = r_ready;
    assign data_bus_out              = r_data;
    assign data_bus_out_from_chipset = r_from_chipset;
    assign miss_count                = r_miss;

endmodule

// File: tb/tb_kf_bus_decoder.sv
// Scoreboard bench for kf_bus_decoder: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_kf_bus_decoder;

    localparam int CH = 8;
    localparam int AW = 20;
    localparam int DW = 8;
    localparam int WW = 3;

    localparam logic [3:0] IOR  = 4'b1110;
    localparam logic [3:0] IOW  = 4'b1101;
    localparam logic [3:0] MEMR = 4'b1011;
    localparam logic [3:0] MEMW = 4'b0111;
    localparam logic [3:0] IORW = 4'b1100;

    localparam logic [4:0] M_CS  = 5'b00001;
    localparam logic [4:0] M_RDY = 5'b00010;
    localparam logic [4:0] M_D   = 5'b00100;
    localparam logic [4:0] M_FC  = 5'b01000;
    localparam logic [4:0] M_MC  = 5'b10000;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [3:0]        cmd_n;
    logic              aen_n;
    logic [AW-1:0]     address;
    logic [CH*DW-1:0]  ch_data;
    logic              cfg_write;
    logic [3:0]        cfg_channel;
    logic              cfg_enable;
    logic              cfg_memory;
    logic [AW-1:0]     cfg_base;
    logic [AW-1:0]     cfg_mask;
    logic [WW-1:0]     cfg_wait;
    logic [CH-1:0]     chip_select_n;
    logic              io_channel_ready;
    logic [DW-1:0]     data_bus_out;
    logic              data_bus_out_from_chipset;
    logic [7:0]        miss_count;

    kf_bus_decoder #(
        .CHANNELS   (CH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_WIDTH (WW)
    ) dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .io_read_command_n         (cmd_n[0]),
        .io_write_command_n        (cmd_n[1]),
        .memory_read_command_n     (cmd_n[2]),
        .memory_write_command_n    (cmd_n[3]),
        .address_enable_n          (aen_n),
        .address                   (address),
        .channel_data_bus_out      (ch_data),
        .cfg_write                 (cfg_write),
        .cfg_channel               (cfg_channel),
        .cfg_enable                (cfg_enable),
        .cfg_memory                (cfg_memory),
        .cfg_base                  (cfg_base),
        .cfg_mask                  (cfg_mask),
        .cfg_wait                  (cfg_wait),
        .chip_select_n             (chip_select_n),
        .io_channel_ready          (io_channel_ready),
        .data_bus_out              (data_bus_out),
        .data_bus_out_from_chipset (data_bus_out_from_chipset),
        .miss_count                (miss_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [4:0] m;
        logic [7:0] cs;
        logic       rdy;
        logic [7:0] d;
        logic       fc;
        logic [7:0] mc;
    } exp_t;

    exp_t  sb_q[$];
    string sb_name[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic sb_push(input int at, input string nm, input logic [4:0] m,
                           input logic [7:0] cs, input logic rdy, input logic [7:0] d,
                           input logic fc, input logic [7:0] mc);
        exp_t e;
        e.at = at; e.m = m; e.cs = cs; e.rdy = rdy; e.d = d; e.fc = fc; e.mc = mc;
        sb_q.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic chk(input string nm, input string fld, input logic [7:0] act,
                       input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%02h, required 0x%02h (cycle %0d)", nm, fld, act, req, cyc);
        end
    endtask

    // Monitor: compare every expectation whose cycle has come up.
    always @(negedge clock) begin
        exp_t  e;
        string nm;
        while (sb_q.size() != 0 && sb_q[0].at <= cyc) begin
            e  = sb_q.pop_front();
            nm = sb_name.pop_front();
            if (e.at != cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", nm, cyc, e.at);
            end else begin
                if (e.m[0]) chk(nm, "cs_n",  chip_select_n, e.cs);
                if (e.m[1]) chk(nm, "ready", {7'd0, io_channel_ready}, {7'd0, e.rdy});
                if (e.m[2]) chk(nm, "data",  data_bus_out, e.d);
                if (e.m[3]) chk(nm, "from_chipset", {7'd0, data_bus_out_from_chipset}, {7'd0, e.fc});
                if (e.m[4]) chk(nm, "miss",  miss_count, e.mc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input int ch, input logic en, input logic mem, input logic [AW-1:0] base,
                       input logic [AW-1:0] mask, input logic [WW-1:0] w);
        cfg_channel = 4'(ch);
        cfg_enable  = en;
        cfg_memory  = mem;
        cfg_base    = base;
        cfg_mask    = mask;
        cfg_wait    = w;
        cfg_write   = 1'b1;
        tick();
        cfg_write   = 1'b0;
    endtask

    // Hold a command for n edges, release it, then let the decoder recover.
    task automatic run_cmd(input logic [3:0] c, input logic [AW-1:0] a, input int n,
                           input logic aen);
        address = a;
        aen_n   = aen;
        cmd_n   = c;
        repeat (n) tick();
        cmd_n = 4'hF;
        aen_n = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int exp_miss;
        reset_n = 1'b0; cmd_n = 4'hF; aen_n = 1'b0; address = '0;
        cfg_write = 1'b0; cfg_channel = '0; cfg_enable = 1'b0; cfg_memory = 1'b0;
        cfg_base = '0; cfg_mask = '0; cfg_wait = '0;
        for (int i = 0; i < CH; i++) ch_data[i*DW +: DW] = 8'hA0 + 8'(i);
        ch_data[15:8] = 8'h5A;

        tick(); tick();
        sb_push(cyc, "reset", 5'h1F, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();

        // I/O read on ch1, no wait states
        cfg(1, 1'b1, 1'b0, 20'h00020, 20'hFFFE0, 3'd0);
        k = cyc + 1;
        sb_push(k,     "t1_cs",  M_CS | M_RDY | M_FC, 8'hFD, 1'b1, 8'h00, 1'b0, 8'h00);
        sb_push(k + 1, "t1_rd",  M_CS | M_RDY | M_D | M_FC, 8'hFD, 1'b1, 8'h5A, 1'b1, 8'h00);
        sb_push(k + 2, "t1_end", M_CS | M_RDY | M_D | M_FC, 8'hFF, 1'b1, 8'h5A, 1'b0, 8'h00);
        run_cmd(IOR, 20'h00021, 2, 1'b0);

        // Memory write on ch4 with 3 wait states
        cfg(4, 1'b1, 1'b1, 20'hB8000, 20'hFC000, 3'd3);
        k = cyc + 1;
        sb_push(k,     "t2_w0",   M_CS | M_RDY | M_FC, 8'hEF, 1'b0, 8'h00, 1'b0, 8'h00);
        sb_push(k + 1, "t2_w1",   M_RDY, 8'hEF, 1'b0, 8'h00, 1'b0, 8'h00);
        sb_push(k + 2, "t2_w2",   M_RDY, 8'hEF, 1'b0, 8'h00, 1'b0, 8'h00);
        sb_push(k + 3, "t2_rdy",  M_CS | M_RDY | M_D | M_FC, 8'hEF, 1'b1, 8'h5A, 1'b0, 8'h00);
        sb_push(k + 4, "t2_hold", M_CS | M_RDY, 8'hEF, 1'b1, 8'h00, 1'b0, 8'h00);
        sb_push(k + 5, "t2_end",  M_CS | M_RDY, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00);
        run_cmd(MEMW, 20'hB8010, 5, 1'b0);

        // Overlapping windows: lowest index wins
        cfg(2, 1'b1, 1'b0, 20'h00300, 20'hFFFF0, 3'd0);
        cfg(5, 1'b1, 1'b0, 20'h00300, 20'hFFFF0, 3'd0);
        k = cyc + 1;
        sb_push(k,     "t3_cs", M_CS, 8'hFB, 1'b1, 8'h00, 1'b0, 8'h00);
        sb_push(k + 1, "t3_rd", M_CS | M_D | M_FC, 8'hFB, 1'b1, 8'hA2, 1'b1, 8'h00);
        run_cmd(IOR, 20'h00305, 2, 1'b0);

        // Reconfigure ch1 mid-access; address also moves after decode
        cfg(1, 1'b1, 1'b0, 20'h00020, 20'hFFFE0, 3'd2);
        k = cyc + 1;
        sb_push(k,     "t4_w0",  M_CS | M_RDY, 8'hFD, 1'b0, 8'h00, 1'b0, 8'h00);
        sb_push(k + 1, "t4_w1",  M_CS | M_RDY, 8'hFD, 1'b0, 8'h00, 1'b0, 8'h00);
        sb_push(k + 2, "t4_rdy", M_CS | M_RDY | M_FC, 8'hFD, 1'b1, 8'h00, 1'b0, 8'h00);
        sb_push(k + 3, "t4_rd",  M_CS | M_D | M_FC, 8'hFD, 1'b1, 8'h5A, 1'b1, 8'h00);
        sb_push(k + 4, "t4_rd2", M_CS | M_D | M_FC, 8'hFD, 1'b1, 8'h5A, 1'b1, 8'h00);
        sb_push(k + 5, "t4_end", M_CS | M_FC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00);
        address = 20'h00021; aen_n = 1'b0; cmd_n = IOR;
        tick();
        cfg_channel = 4'd1; cfg_enable = 1'b1; cfg_memory = 1'b0;
        cfg_base = 20'h00040; cfg_mask = 20'hFFFE0; cfg_wait = 3'd0;
        cfg_write = 1'b1;
        address = 20'h00041;
        tick();
        cfg_write = 1'b0;
        tick(); tick(); tick();
        cmd_n = 4'hF;
        tick(); tick();
        exp_miss = 1;
        k = cyc + 1;
        sb_push(k, "t4_old", M_CS | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'(exp_miss));
        run_cmd(IOR, 20'h00021, 1, 1'b0);
        k = cyc + 1;
        sb_push(k,     "t4_new",    M_CS | M_RDY, 8'hFD, 1'b1, 8'h00, 1'b0, 8'h00);
        sb_push(k + 1, "t4_new_rd", M_D | M_FC, 8'hFF, 1'b1, 8'h5A, 1'b1, 8'h00);
        run_cmd(IOR, 20'h00041, 2, 1'b0);

        // Out-of-range window index is ignored
        cfg(12, 1'b1, 1'b0, 20'h00500, 20'hFFFF0, 3'd0);
        exp_miss = 2;
        k = cyc + 1;
        sb_push(k, "t5_ign", M_CS | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'(exp_miss));
        run_cmd(IOR, 20'h00500, 1, 1'b0);
        k = cyc + 1;
        sb_push(k, "t5_ch4", M_CS | M_RDY, 8'hEF, 1'b0, 8'h00, 1'b0, 8'h00);
        run_cmd(MEMW, 20'hB8010, 4, 1'b0);

        // Misses: no hit, two commands at once, wrong space, bus not CPU-owned
        exp_miss = 3;
        k = cyc + 1;
        sb_push(k, "m_nohit", M_CS | M_FC | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'(exp_miss));
        run_cmd(IOR, 20'h00400, 1, 1'b0);
        exp_miss = 4;
        k = cyc + 1;
        sb_push(k, "m_dual", M_CS | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'(exp_miss));
        run_cmd(IORW, 20'h00041, 1, 1'b0);
        exp_miss = 5;
        k = cyc + 1;
        sb_push(k, "m_space", M_CS | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'(exp_miss));
        run_cmd(MEMR, 20'h00041, 1, 1'b0);
        k = cyc + 1;
        sb_push(k, "m_aen", M_CS | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'(exp_miss));
        run_cmd(IOR, 20'h00041, 1, 1'b1);
        for (int i = 6; i <= 300; i++) begin
            run_cmd(IOR, 20'h00400, 1, 1'b0);
            if (i == 254) sb_push(cyc, "m_254", M_CS | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd254);
            if (i == 256) sb_push(cyc, "m_sat", M_CS | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd255);
        end
        sb_push(cyc, "m_300", M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd255);
        tick();

        // Asynchronous reset in the middle of a 7-wait access
        cfg(3, 1'b1, 1'b0, 20'h00060, 20'hFFFF0, 3'd7);
        k = cyc + 1;
        sb_push(k, "r_wait", M_CS | M_RDY, 8'hF7, 1'b0, 8'h00, 1'b0, 8'h00);
        address = 20'h00061; aen_n = 1'b0; cmd_n = IOW;
        tick(); tick();
        #1;
        reset_n = 1'b0;
        sb_push(cyc, "r_async", 5'h1F, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00);
        tick();
        reset_n = 1'b1;
        cmd_n = 4'hF;
        tick();
        k = cyc + 1;
        sb_push(k, "r_clr", M_CS | M_MC, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd1);
        run_cmd(IOR, 20'h00061, 1, 1'b0);
        cfg(3, 1'b1, 1'b0, 20'h00060, 20'hFFFF0, 3'd0);
        k = cyc + 1;
        sb_push(k,     "r_next",    M_CS | M_RDY, 8'hF7, 1'b1, 8'h00, 1'b0, 8'h00);
        sb_push(k + 1, "r_next_rd", M_D | M_FC, 8'hFF, 1'b1, 8'hA3, 1'b1, 8'h00);
        run_cmd(IOR, 20'h00061, 2, 1'b0);

        repeat (3) tick();
        while (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d never checked", sb_name[0], sb_q[0].at);
            void'(sb_q.pop_front());
            void'(sb_name.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
